// File: rtl/hazard_scoreboard_pkg.sv
// Shared types, default parameters and counter-width derivation for the
// ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int NUM_REGS_DEF    = 8;
    localparam int REG_BITS_DEF    = 3;
    localparam int WB_DIST_DEF     = 3;
    localparam int LOAD_EXTRA_DEF  = 1;
    localparam int STALL_CNT_W_DEF = 16;

    typedef logic [REG_BITS_DEF-1:0] reg_idx_t;

    // Countdown width able to hold WB_DIST (and therefore LOAD_EXTRA <= WB_DIST).
    function automatic int cw_of(input int wb_dist);
        return (wb_dist < 1) ? 1 : $clog2(wb_dist + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: writeback countdown W and forward countdown R for a
// single architectural register. A load overrides any decrement, so a new
// write to the same register always wins over the old entry.
module hazard_scoreboard_sb_entry #(
    parameter int CW         = 2,
    parameter int WB_DIST    = 3,
    parameter int LOAD_EXTRA = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          is_load_i,
    input  logic          hold_i,
    output logic [CW-1:0] w_o,
    output logic [CW-1:0] r_o,
    output logic          pending_o
);

    logic [CW-1:0] w_q, w_d;
    logic [CW-1:0] r_q, r_d;

    // Next-state: load new countdowns, else decrement nonzero counters unless frozen.
    always_comb begin
        w_d = w_q;
        r_d = r_q;
        if (load_i) begin
            w_d = CW'(WB_DIST);
            r_d = is_load_i ? CW'(LOAD_EXTRA) : '0;
        end else if (!hold_i) begin
            if (w_q != '0) w_d = w_q - CW'(1);
            if (r_q != '0) r_d = r_q - CW'(1);
        end
    end

    // Countdown registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            r_q <= '0;
        end else begin
            w_q <= w_d;
            r_q <= r_d;
        end
    end

    assign w_o       = w_q;
    assign r_o       = r_q;
    assign pending_o = (w_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register write tracking, operand hazard
// detection, stall/freeze priority and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int REG_BITS    = REG_BITS_DEF,
    parameter int WB_DIST     = WB_DIST_DEF,
    parameter int LOAD_EXTRA  = LOAD_EXTRA_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    input  logic [REG_BITS-1:0]    id_rs_i,
    input  logic                   id_rs_used_i,
    input  logic [REG_BITS-1:0]    id_rt_i,
    input  logic                   id_rt_used_i,
    input  logic                   id_br_use_i,
    input  logic                   id_reg_write_i,
    input  logic [REG_BITS-1:0]    id_writereg_i,
    input  logic                   id_mem_read_i,
    input  logic                   flush_i,
    input  logic                   mem_busy_i,
    output logic                   pc_write_o,
    output logic                   ifid_write_o,
    output logic                   stall_o,
    output logic                   freeze_o,
    output logic [NUM_REGS-1:0]    pending_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    localparam int CW = cw_of(WB_DIST);

    logic [CW-1:0]          w_arr [NUM_REGS];
    logic [CW-1:0]          r_arr [NUM_REGS];
    logic                   rs_hz;
    logic                   rt_hz;
    logic                   hz;
    logic                   issue;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        hazard_scoreboard_sb_entry #(
            .CW         (CW),
            .WB_DIST    (WB_DIST),
            .LOAD_EXTRA (LOAD_EXTRA)
        ) u_sb_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_i    (issue && (id_writereg_i == REG_BITS'(g))),
            .is_load_i (id_mem_read_i),
            .hold_i    (mem_busy_i),
            .w_o       (w_arr[g]),
            .r_o       (r_arr[g]),
            .pending_o (pending_o[g])
        );
    end

    // Operand hazards: rs may be consumed in ID (needs writeback) or in EX
    // (needs forwardable result); rt is only consumed in EX.
    always_comb begin
        rs_hz = (id_br_use_i && (w_arr[id_rs_i] != '0))
             || (id_rs_used_i && (r_arr[id_rs_i] != '0));
        rt_hz = id_rt_used_i && (r_arr[id_rt_i] != '0);
        hz    = id_valid_i && !flush_i && (rs_hz || rt_hz);
    end

    // Output priority: memory freeze over hazard stall over normal advance.
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        stall_o      = 1'b0;
        freeze_o     = 1'b0;
        if (mem_busy_i) begin
            freeze_o     = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (hz) begin
            stall_o      = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end
    end

    assign issue = id_valid_i && id_reg_write_i && !stall_o && !flush_i && !mem_busy_i;

    // Saturating stall-cycle counter; freeze cycles are not stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard. The reference model
// tracks, per register, the absolute "active cycle" up to which the write
// is still outstanding; active time only advances while memory is not busy.
module tb_hazard_scoreboard;

    localparam int NR  = 8;
    localparam int RB  = 3;
    localparam int WB  = 3;
    localparam int LX  = 1;
    localparam int SCW = 10;   // narrow counter so saturation is reachable quickly

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid, id_rs_used, id_rt_used, id_br_use;
    logic           id_reg_write, id_mem_read, flush, mem_busy;
    logic [RB-1:0]  id_rs, id_rt, id_writereg;
    logic           pc_write, ifid_write, stall, freeze;
    logic [NR-1:0]  pending;
    logic [SCW-1:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    int tick;
    int wb_end  [NR];
    int fwd_end [NR];
    int exp_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS(NR), .REG_BITS(RB), .WB_DIST(WB), .LOAD_EXTRA(LX), .STALL_CNT_W(SCW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rs_used_i   (id_rs_used),
        .id_rt_i        (id_rt),
        .id_rt_used_i   (id_rt_used),
        .id_br_use_i    (id_br_use),
        .id_reg_write_i (id_reg_write),
        .id_writereg_i  (id_writereg),
        .id_mem_read_i  (id_mem_read),
        .flush_i        (flush),
        .mem_busy_i     (mem_busy),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .stall_o        (stall),
        .freeze_o       (freeze),
        .pending_o      (pending),
        .stall_cycles_o (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        tick    = 0;
        exp_cnt = 0;
        for (int i = 0; i < NR; i++) begin
            wb_end[i]  = -1;
            fwd_end[i] = -1;
        end
    endfunction

    // Apply one cycle of ID inputs (called at negedge), check, then advance the model.
    task automatic cyc(input logic v, input int rs, input logic rsu, input int rt,
                       input logic rtu, input logic br, input logic rw, input int wr,
                       input logic ld, input logic fl, input logic mb);
        logic          hz_e, stall_e;
        logic [NR-1:0] pend_e;
        id_valid = v;  id_rs = RB'(rs); id_rs_used = rsu; id_rt = RB'(rt);
        id_rt_used = rtu; id_br_use = br; id_reg_write = rw; id_writereg = RB'(wr);
        id_mem_read = ld; flush = fl; mem_busy = mb;
        #1;
        hz_e = v && !fl && ((rsu && tick <= fwd_end[rs]) ||
                            (br  && tick <= wb_end[rs])  ||
                            (rtu && tick <= fwd_end[rt]));
        stall_e = !mb && hz_e;
        for (int i = 0; i < NR; i++) pend_e[i] = (tick <= wb_end[i]);
        chk("stall",        32'(stall),        32'(stall_e));
        chk("pc_write",     32'(pc_write),     32'(!mb && !hz_e));
        chk("ifid_write",   32'(ifid_write),   32'(!mb && !hz_e));
        chk("freeze",       32'(freeze),       32'(mb));
        chk("pending",      32'(pending),      32'(pend_e));
        chk("stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
        @(posedge clk);
        if (!mb) begin
            if (v && rw && !stall_e && !fl) begin
                wb_end[wr]  = tick + WB;
                fwd_end[wr] = tick + (ld ? LX : 0);
            end
            if (stall_e && exp_cnt < (1 << SCW) - 1) exp_cnt++;
            tick++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = '0; id_rs_used = 0; id_rt = '0; id_rt_used = 0;
        id_br_use = 0; id_reg_write = 0; id_writereg = '0; id_mem_read = 0;
        flush = 0; mem_busy = 0;
        model_reset();
        #12;
        chk("rst_pending", 32'(pending), 0);
        chk("rst_cnt",     32'(stall_cycles), 0);
        chk("rst_pc",      32'(pc_write), 1);
        chk("rst_stall",   32'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // load r2, consumer reads rt=r2 in EX: one stall then proceed
        cyc(1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        cyc(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        chk("load_use_cnt", 32'(stall_cycles), 1);
        idle(4);

        // ALU r3 then EX reader: no stall
        cyc(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        cyc(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        idle(4);
        // ALU r3 then branch on r3: stalls while W counts down
        cyc(1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("br_cnt", 32'(stall_cycles), 4);
        idle(4);

        // load r4, dependent in ID under 5 busy cycles, then 1 stall
        cyc(1, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("busy_cnt", 32'(stall_cycles), 5);
        idle(4);

        // hazard with flush: no stall, no entry for r7
        cyc(1, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0);
        cyc(1, 6, 1, 6, 1, 1, 1, 7, 0, 1, 0);
        chk("flush_r7", 32'(pending[7]), 0);
        idle(4);

        // reissue r5 exactly as W goes 1->0
        cyc(1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        idle(3);
        idle(2);

        // saturate the stall counter with repeated branch-on-r1 stalls
        for (int k = 0; k < 1400; k++) begin
            if (k % 4 == 0) cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
            else            cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        end
        chk("sat_cnt", 32'(stall_cycles), (1 << SCW) - 1);

        // asynchronous reset while stalled
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        id_valid = 1; id_rs = 3'd1; id_br_use = 1; id_reg_write = 0;
        #1;
        chk("pre_rst_stall", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pending", 32'(pending), 0);
        chk("async_cnt",     32'(stall_cycles), 0);
        chk("async_pc",      32'(pc_write), 1);
        chk("async_stall",   32'(stall), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 9) != 0,
                int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0,
                int'($urandom_range(0, NR - 1)),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed 8-register load-use/branch hazard detector. Tracks every in-flight register write in a per-register scoreboard with countdown timers rather than comparing fixed pipeline-stage fields. Decides stall, bubble and freeze for the ID stage of the 5-stage pipeline. Supports:
- configurable register count and load latency;
- ID-resolved branch/jalr operands;
- a global memory-busy freeze;
- a saturating stall-cycle counter for performance monitoring.

Parameters:
NUM_REGS, 8, architectural register count (power of two)
REG_BITS, 3, register index width, log2(NUM_REGS)
WB_DIST, 3, cycles from ID issue until the result is written to the register file (EX, MEM, WB)
LOAD_EXTRA, 1, extra cycles before a load result can be forwarded to an EX consumer
STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_BITS  ID source A
id_rs_used  in  1  source A is read
id_rt  in  REG_BITS  ID source B
id_rt_used  in  1  source B is read
id_br_use  in  1  instruction resolves in ID using rs (branch/jalr)
id_reg_write  in  1  instruction writes a register
id_writereg  in  REG_BITS  destination register
id_mem_read  in  1  instruction is a load
flush  in  1  kill the ID instruction (taken branch/jump)
mem_busy  in  1  data memory not ready; freeze the pipeline
pc_write  out  1  PC may advance
ifid_write  out  1  IF/ID may load
stall  out  1  inject a bubble into ID/EX
freeze  out  1  hold all pipeline registers
pending  out  NUM_REGS  per-register write-pending bits
stall_cycles  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all entries invalid; W=0 and R=0 for every register; stall_cycles=0; pending=0.
- Scoreboard entry per register: CW-bit writeback countdown W and forward countdown R, where CW = clog2(WB_DIST+1). An entry is valid (pending bit = 1) when W != 0.
- Issue condition: id_valid & id_reg_write & ~stall & ~flush & ~mem_busy. On issue, entry[id_writereg] gets W=WB_DIST and R = id_mem_read ? LOAD_EXTRA : 0, visible next cycle.
- Countdown: every cycle with mem_busy=0, each nonzero W and R decrements by 1; both saturate at 0. When mem_busy=1 all counters hold.
- Same-register collision: an issue to register r in the same cycle that r's old entry decrements or expires takes priority; the new values are loaded.
- A newer write to the same register (WAW) overwrites the older entry.
- Operand hazard (combinational from current state and ID inputs), per source s:
  - ID-resolved use: hazard if (s is rs & id_br_use & W[s]!=0).
  - EX use: hazard if (s is used & R[s]!=0).
- hz = id_valid & ~flush & OR of the per-source hazards.
- Outputs:
  - If mem_busy=1: freeze=1, pc_write=0, ifid_write=0, stall=0. Freeze has priority over hz.
  - Else if hz=1: stall=1, pc_write=0, ifid_write=0, freeze=0.
  - Else: pc_write=1, ifid_write=1, stall=0, freeze=0.
- flush=1 never stalls. The flushed instruction is neither checked nor issued.
- stall_cycles increments on each cycle with stall=1 and saturates at all-ones. Freeze cycles are not counted.
- Latency: a stall deasserts in the first cycle the offending counter reads 0. No extra registered delay.
- Reset mid-operation clears all state immediately (asynchronous). Outputs return to their default values.

Decomposition:
- Shared package holds: register-index typedef sized by REG_BITS; the WB_DIST and LOAD_EXTRA defaults; CW derivation.
- One natural sub-module, sb_entry: one register's W/R countdown pair with load, decrement, hold and the pending output. It is instantiated NUM_REGS times via generate.
- The top level holds the hazard compare, output priority logic and stall counter.

Test Plan:
- Load r2 issued, next ID instruction reads rt=r2 -> stall=1 for exactly 1 cycle (LOAD_EXTRA=1), then pc_write=1; stall_cycles=1.
- ALU write r3, next instruction reads r3 in EX -> no stall. Next instruction is instead a branch using rs=r3 -> stall for 3 cycles (W=3), released when pending[3]=0.
- Load r4 then mem_busy=1 for 5 cycles with a dependent instruction in ID -> freeze=1, stall=0 and counters hold. After mem_busy drops: 1 stall cycle, then proceed; stall_cycles increases by 1 only.
- Hazard present and flush=1 in the same cycle -> stall=0, no entry created for id_writereg.
- Issue to r5 in the cycle r5's W goes 1->0 -> pending[5] stays 1 with W=3.
- rst_n asserted low while stalled with pending=8'hFF and stall_cycles=16'hFFFF (saturated) -> outputs reset asynchronously, before the next clock edge: pending=0, stall_cycles=0, pc_write=1.
